// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: FSM encoding and divide-by-zero result.
package mdu_pkg;
  localparam int          WIDTH         = 32;
  localparam logic [1:0]  S_IDLE        = 2'd0;
  localparam logic [1:0]  S_CALC        = 2'd1;
  localparam logic [1:0]  S_DONE        = 2'd2;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/zero_num.sv
// Leading-zero counter for a 32-bit word; returns 0..32 (32 when the word is zero).
module zero_num (
  input  logic [31:0] a,
  output logic [5:0]  cnt
);
  // Scan upward so the highest set bit wins the last assignment.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) cnt = 6'(31 - i);
    end
  end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. The dividend is pre-normalised by its
// leading-zero count, so only significant bits are iterated (1..32 iterations).
module div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, prem_q, prem_d, qacc_q, qacc_d, dsor_q, dsor_d;
  logic [5:0]       k_q, k_d;
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  logic             neg_a, neg_b, accept, div0, zero_a, qbit;
  logic [WIDTH-1:0] abs_a, abs_b, rem_nxt, q_nxt;
  logic [WIDTH:0]   rem33, diff;
  logic [5:0]       lz;

  assign neg_a  = sign & dividend[WIDTH-1];
  assign neg_b  = sign & divisor[WIDTH-1];
  assign abs_a  = neg_if(dividend, neg_a);
  assign abs_b  = neg_if(divisor, neg_b);
  assign div0   = (divisor == '0);
  assign zero_a = (abs_a == '0);
  // CALC is the only state that ignores start; a new op may launch straight from DONE.
  assign accept = start & (state_q != S_CALC);

  zero_num u_lz (.a(abs_a), .cnt(lz));

  // One restoring step: single 33-bit subtract decides the quotient bit.
  always_comb begin
    rem33   = {prem_q, dvd_q[WIDTH-1]};
    diff    = rem33 - {1'b0, dsor_q};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : rem33[WIDTH-1:0];
    q_nxt   = {qacc_q[WIDTH-2:0], qbit};
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      qacc_q  <= '0;
      dsor_q  <= '0;
      k_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      qacc_q  <= qacc_d;
      dsor_q  <= dsor_d;
      k_q     <= k_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end

  // Next-state: divide-by-zero and zero dividend bypass CALC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CALC:  if (k_q == 6'd1) state_d = S_DONE;
      default: begin
        if (accept) state_d = (div0 || zero_a) ? S_DONE : S_CALC;
        else        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; results only change on entry to DONE.
  always_comb begin
    busy_d  = (state_d == S_CALC);
    done_d  = (state_d == S_DONE);
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    qacc_d  = qacc_q;
    dsor_d  = dsor_q;
    k_d     = k_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    if (accept) begin
      neg_a_d = neg_a;
      neg_b_d = neg_b;
      dsor_d  = abs_b;
      dvd_d   = abs_a << lz;
      k_d     = 6'd32 - lz;
      prem_d  = '0;
      qacc_d  = '0;
      if (div0) begin
        quot_d = DIV0_QUOTIENT;
        rem_d  = dividend;
      end else if (zero_a) begin
        quot_d = '0;
        rem_d  = '0;
      end
    end else if (state_q == S_CALC) begin
      prem_d = rem_nxt;
      qacc_d = q_nxt;
      dvd_d  = dvd_q << 1;
      k_d    = k_q - 6'd1;
      // Remainder follows the dividend's sign; quotient sign is the XOR.
      if (k_q == 6'd1) begin
        quot_d = neg_if(q_nxt, neg_a_q ^ neg_b_q);
        rem_d  = neg_if(rem_nxt, neg_a_q);
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, busy window, signed/unsigned results,
// divide-by-zero, ignored start, mid-run reset and back-to-back operation.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, sign;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] quotient, remainder;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands for one edge, then scramble them so latching is exercised.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; sign = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; sign = ~s; dividend = 32'hDEAD_BEEF; divisor = 32'h1234_5678;
  endtask

  // Called at the cycle-1 sample point; returns at the done sample point.
  task automatic wait_done(input string tag, input int lat, input int poke, input int rst_at);
    int c;
    int bcnt;
    bit seen;
    c = 1; bcnt = 0; seen = 1'b0;
    while (c <= 64 && !seen) begin
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_rst_q"}, quotient, 32'd0);
        chk({tag, "_rst_r"}, remainder, 32'd0);
        return;
      end
      if (done) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        if (c == poke) begin
          start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        end else start = 1'b0;
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, seen ? 32'(c) : 32'd0, 32'(lat));
    chk({tag, "_busycnt"}, 32'(bcnt), 32'(lat - 1));
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] eq, input logic [31:0] er);
    launch(s, a, b);
    wait_done(tag, lat, 0, 0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    @(negedge clk);
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("divu_100_7",  1'b0, 32'd100,       32'd7,         8,  32'd14,        32'd2);
    do_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         4,  32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 4,  32'hFFFF_FFFD, 32'd1);
    do_div("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    do_div("divu_5_0",    1'b0, 32'd5,         32'd0,         1,  32'hFFFF_FFFF, 32'd5);
    do_div("div_m7_0",    1'b1, 32'hFFFF_FFF9, 32'd0,         1,  32'hFFFF_FFFF, 32'hFFFF_FFF9);
    do_div("divu_0_3",    1'b0, 32'd0,         32'd3,         1,  32'd0,         32'd0);
    do_div("divu_big",    1'b0, 32'hFFFF_FFFF, 32'd7,         33, 32'h2492_4924, 32'd3);

    // start pulsed mid-run must not disturb the running division
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);
    wait_done("ignore", 33, 5, 0);
    chk("ignore_q", quotient, 32'h5555_5555);
    chk("ignore_r", remainder, 32'd0);
    @(negedge clk);

    // reset during CALC aborts and clears outputs
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);
    wait_done("abort", 0, 0, 10);
    do_div("after_rst", 1'b0, 32'd100, 32'd7, 8, 32'd14, 32'd2);

    // back-to-back: second start issued in the first op's DONE cycle
    launch(1'b0, 32'd9, 32'd2);
    wait_done("b2b_a", 5, 0, 0);
    chk("b2b_a_q", quotient, 32'd4);
    chk("b2b_a_r", remainder, 32'd1);
    launch(1'b0, 32'd10, 32'd3);
    chk("b2b_done_drop", {31'd0, done}, 32'd0);
    chk("b2b_q_held", quotient, 32'd4);
    wait_done("b2b_b", 5, 0, 0);
    chk("b2b_b_q", quotient, 32'd3);
    chk("b2b_b_r", remainder, 32'd1);
    @(negedge clk);
    chk("b2b_b_drop", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
